// File: rtl/completion_marker.sv
// rtl/completion_marker.sv - TX completion table: tag allocation, response marking, read-data store.
// Define CM_ERR_CNT_EN to add saturating unexp_cnt/dup_cnt error counters.
module completion_marker #(
  parameter int TAGS = 64,
  parameter int TW   = 6,
  parameter int DW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_req,
  input  logic            alloc_wr,
  output logic            alloc_gnt,
  output logic [TW-1:0]   alloc_tag,
  input  logic            rsp_valid,
  input  logic            rsp_is_rd,
  input  logic [TW-1:0]   rsp_tag,
  input  logic [DW-1:0]   rsp_data,
  input  logic            clr_en,
  input  logic [TW-1:0]   clr_tag,
  output logic [TAGS-1:0] wr_done,
  output logic [TAGS-1:0] rd_done,
  output logic [TAGS-1:0] busy,
  input  logic [TW-1:0]   ret_addr,
  output logic [DW-1:0]   ret_data,
  output logic            full,
  output logic            err_unexp,
  output logic            err_dup
`ifdef CM_ERR_CNT_EN
  ,
  output logic [15:0]     unexp_cnt,
  output logic [15:0]     dup_cnt
`endif
);

  logic [TAGS-1:0] busy_q, busy_d;
  logic [TAGS-1:0] is_wr_q, is_wr_d;
  logic [TAGS-1:0] done_q, done_d;
  logic [DW-1:0]   ret_data_q, ret_data_d;
  logic            err_unexp_q, err_unexp_d;
  logic            err_dup_q, err_dup_d;
  logic [DW-1:0]   store_q [TAGS];
  logic            rsp_ok;
  logic            rsp_keep;
  logic            store_we;
`ifdef CM_ERR_CNT_EN
  logic [15:0]     unexp_cnt_q, unexp_cnt_d;
  logic [15:0]     dup_cnt_q, dup_cnt_d;
`endif

  // Lowest free index wins; scanning downward leaves the smallest one.
  always_comb begin
    alloc_gnt = ~(&busy_q);
    alloc_tag = '0;
    for (int i = TAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_tag = TW'(i);
    end
  end

  always_comb begin
    busy_d      = busy_q;
    is_wr_d     = is_wr_q;
    done_d      = done_q;
    err_unexp_d = 1'b0;
    err_dup_d   = 1'b0;
    rsp_ok      = 1'b0;
    if (rsp_valid) begin
      if (!busy_q[rsp_tag] || (rsp_is_rd == is_wr_q[rsp_tag])) err_unexp_d = 1'b1;
      else if (done_q[rsp_tag])                                 err_dup_d   = 1'b1;
      else                                                      rsp_ok      = 1'b1;
    end
    // A retire of the same tag on this edge discards the response's update.
    rsp_keep = rsp_ok && !(clr_en && (clr_tag == rsp_tag));
    store_we = rsp_keep && rsp_is_rd;
    if (rsp_keep) done_d[rsp_tag] = 1'b1;
    if (clr_en) begin
      busy_d[clr_tag] = 1'b0;
      done_d[clr_tag] = 1'b0;
    end
    if (alloc_req && alloc_gnt) begin
      busy_d[alloc_tag]  = 1'b1;
      is_wr_d[alloc_tag] = alloc_wr;
      done_d[alloc_tag]  = 1'b0;
    end
    ret_data_d = store_q[ret_addr];
  end

`ifdef CM_ERR_CNT_EN
  always_comb begin
    unexp_cnt_d = unexp_cnt_q;
    dup_cnt_d   = dup_cnt_q;
    if (err_unexp_d && (unexp_cnt_q != 16'hFFFF)) unexp_cnt_d = unexp_cnt_q + 16'd1;
    if (err_dup_d && (dup_cnt_q != 16'hFFFF))     dup_cnt_d   = dup_cnt_q + 16'd1;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      is_wr_q     <= '0;
      done_q      <= '0;
      ret_data_q  <= '0;
      err_unexp_q <= 1'b0;
      err_dup_q   <= 1'b0;
`ifdef CM_ERR_CNT_EN
      unexp_cnt_q <= '0;
      dup_cnt_q   <= '0;
`endif
    end else begin
      busy_q      <= busy_d;
      is_wr_q     <= is_wr_d;
      done_q      <= done_d;
      ret_data_q  <= ret_data_d;
      err_unexp_q <= err_unexp_d;
      err_dup_q   <= err_dup_d;
`ifdef CM_ERR_CNT_EN
      unexp_cnt_q <= unexp_cnt_d;
      dup_cnt_q   <= dup_cnt_d;
`endif
    end
  end

  // Data store has no reset; only ret_data is cleared.
  always_ff @(posedge clk) begin
    if (store_we) store_q[rsp_tag] <= rsp_data;
  end

  assign wr_done   = busy_q & done_q & is_wr_q;
  assign rd_done   = busy_q & done_q & ~is_wr_q;
  assign busy      = busy_q;
  assign full      = &busy_q;
  assign ret_data  = ret_data_q;
  assign err_unexp = err_unexp_q;
  assign err_dup   = err_dup_q;
`ifdef CM_ERR_CNT_EN
  assign unexp_cnt = unexp_cnt_q;
  assign dup_cnt   = dup_cnt_q;
`endif

endmodule

// File: tb/tb_completion_marker.sv
// tb/tb_completion_marker.sv - directed bench with per-tag table model for completion_marker.
module tb_completion_marker;
  localparam int TAGS = 64;
  localparam int TW   = 6;
  localparam int DW   = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            alloc_req = 1'b0, alloc_wr = 1'b0;
  logic            alloc_gnt;
  logic [TW-1:0]   alloc_tag;
  logic            rsp_valid = 1'b0, rsp_is_rd = 1'b0;
  logic [TW-1:0]   rsp_tag = '0;
  logic [DW-1:0]   rsp_data = '0;
  logic            clr_en = 1'b0;
  logic [TW-1:0]   clr_tag = '0;
  logic [TAGS-1:0] wr_done, rd_done, busy;
  logic [TW-1:0]   ret_addr = '0;
  logic [DW-1:0]   ret_data;
  logic            full, err_unexp, err_dup;
`ifdef CM_ERR_CNT_EN
  logic [15:0]     unexp_cnt, dup_cnt;
`endif

  int checks = 0;
  int errors = 0;

  completion_marker #(.TAGS(TAGS), .TW(TW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_wr(alloc_wr),
    .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .rsp_valid(rsp_valid), .rsp_is_rd(rsp_is_rd), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .clr_en(clr_en), .clr_tag(clr_tag),
    .wr_done(wr_done), .rd_done(rd_done), .busy(busy),
    .ret_addr(ret_addr), .ret_data(ret_data),
    .full(full), .err_unexp(err_unexp), .err_dup(err_dup)
`ifdef CM_ERR_CNT_EN
    , .unexp_cnt(unexp_cnt), .dup_cnt(dup_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Table model: one record per tag, updated from the pre-edge view of the table.
  bit          m_busy [TAGS];
  bit          m_wr   [TAGS];
  bit          m_done [TAGS];
  logic [31:0] m_data [TAGS];
  bit          m_known[TAGS];
  bit          e_unexp, e_dup, e_ret_ok;
  logic [31:0] e_ret;
  int          m_free;
  bit          m_accept;

  function automatic int lowest_free();
    for (int i = 0; i < TAGS; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  initial for (int i = 0; i < TAGS; i++) m_known[i] = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAGS; i++) begin
        m_busy[i] = 1'b0; m_wr[i] = 1'b0; m_done[i] = 1'b0;
      end
      e_unexp = 1'b0; e_dup = 1'b0; e_ret = '0; e_ret_ok = 1'b1;
    end else begin
      m_free   = lowest_free();
      e_ret    = m_data[ret_addr];
      e_ret_ok = m_known[ret_addr];
      e_unexp  = 1'b0; e_dup = 1'b0; m_accept = 1'b0;
      if (rsp_valid) begin
        if (!m_busy[rsp_tag])                  e_unexp = 1'b1;
        else if (m_wr[rsp_tag] != !rsp_is_rd)  e_unexp = 1'b1;
        else if (m_done[rsp_tag])              e_dup = 1'b1;
        else                                   m_accept = 1'b1;
      end
      if (m_accept && !(clr_en && clr_tag == rsp_tag)) begin
        m_done[rsp_tag] = 1'b1;
        if (rsp_is_rd) begin m_data[rsp_tag] = rsp_data; m_known[rsp_tag] = 1'b1; end
      end
      if (clr_en) begin m_busy[clr_tag] = 1'b0; m_done[clr_tag] = 1'b0; end
      if (alloc_req && m_free >= 0) begin
        m_busy[m_free] = 1'b1; m_wr[m_free] = alloc_wr; m_done[m_free] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      logic [63:0] eb, ew, er;
      int lf;
      eb = '0; ew = '0; er = '0;
      for (int i = 0; i < TAGS; i++) begin
        eb[i] = m_busy[i];
        ew[i] = m_busy[i] && m_done[i] && m_wr[i];
        er[i] = m_busy[i] && m_done[i] && !m_wr[i];
      end
      lf = lowest_free();
      chk("busy", busy, eb);
      chk("wr_done", wr_done, ew);
      chk("rd_done", rd_done, er);
      chk("full", 64'(full), 64'(lf < 0));
      chk("alloc_gnt", 64'(alloc_gnt), 64'(lf >= 0));
      if (lf >= 0) chk("alloc_tag", 64'(alloc_tag), 64'(lf));
      chk("err_unexp", 64'(err_unexp), 64'(e_unexp));
      chk("err_dup", 64'(err_dup), 64'(e_dup));
      if (e_ret_ok) chk("ret_data", 64'(ret_data), 64'(e_ret));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick(); tick();
    chk("rst_busy", busy, 64'h0);
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_gnt", 64'(alloc_gnt), 64'h1);
    chk("rst_tag", 64'(alloc_tag), 64'h0);
    chk("rst_ret", 64'(ret_data), 64'h0);
    chk("rst_err", 64'({err_unexp, err_dup}), 64'h0);
    rst = 1'b0;
    tick();

    alloc_req = 1'b1; alloc_wr = 1'b1; tick();
    alloc_wr = 1'b0; tick();
    alloc_wr = 1'b1; tick();
    alloc_req = 1'b0;
    chk("three_alloc_busy", busy, 64'h7);
    chk("next_tag", 64'(alloc_tag), 64'd3);

    rsp_valid = 1'b1; rsp_is_rd = 1'b0; rsp_tag = 6'd0; tick();
    rsp_valid = 1'b0;
    chk("ack0_wr_done", wr_done, 64'h1);

    rsp_valid = 1'b1; rsp_is_rd = 1'b1; rsp_tag = 6'd1; rsp_data = 32'hDEADBEEF; ret_addr = 6'd1; tick();
    rsp_valid = 1'b0;
    chk("rd1_rd_done", rd_done, 64'h2);
    tick();
    chk("rd1_ret_data", 64'(ret_data), 64'hDEADBEEF);

    rsp_valid = 1'b1; rsp_is_rd = 1'b0; rsp_tag = 6'd10; tick();
    rsp_valid = 1'b0;
    chk("free_tag_unexp", 64'(err_unexp), 64'h1);
    chk("free_tag_busy", busy, 64'h7);
    tick();
    chk("unexp_one_cycle", 64'(err_unexp), 64'h0);

    rsp_valid = 1'b1; rsp_is_rd = 1'b0; rsp_tag = 6'd1; tick();
    rsp_valid = 1'b0;
    chk("type_mismatch_unexp", 64'(err_unexp), 64'h1);

    rsp_valid = 1'b1; rsp_is_rd = 1'b1; rsp_tag = 6'd1; rsp_data = 32'h12345678; tick();
    rsp_valid = 1'b0;
    chk("dup_err", 64'(err_dup), 64'h1);
    tick();
    chk("dup_ret_kept", 64'(ret_data), 64'hDEADBEEF);

    rsp_valid = 1'b1; rsp_is_rd = 1'b0; rsp_tag = 6'd2; clr_en = 1'b1; clr_tag = 6'd2; tick();
    rsp_valid = 1'b0; clr_en = 1'b0;
    chk("rsp_clr_busy", busy, 64'h3);
    chk("rsp_clr_wr_done", wr_done, 64'h1);

    alloc_req = 1'b1; alloc_wr = 1'b1;
    for (int n = 0; n < 100 && !full; n++) tick();
    chk("fill_full", 64'(full), 64'h1);
    chk("fill_gnt", 64'(alloc_gnt), 64'h0);

    clr_en = 1'b1; clr_tag = 6'd5; tick();
    clr_en = 1'b0;
    chk("clr_full_no_grant", busy, ~(64'h1 << 5));
    chk("freed_tag", 64'(alloc_tag), 64'd5);
    tick();
    chk("regrant_full", 64'(full), 64'h1);

    clr_en = 1'b1; clr_tag = 6'd7; tick();
    clr_en = 1'b0;
    rsp_valid = 1'b1; rsp_is_rd = 1'b0; rsp_tag = 6'd7; tick();
    rsp_valid = 1'b0; alloc_req = 1'b0;
    chk("rsp_on_alloc_unexp", 64'(err_unexp), 64'h1);
    chk("rsp_on_alloc_done", 64'(wr_done[7]), 64'h0);

    rst = 1'b1; tick(); rst = 1'b0; tick();
    alloc_req = 1'b1;
    for (int n = 0; n < 20; n++) tick();
    alloc_req = 1'b0;
    chk("twenty_busy", busy, 64'hFFFFF);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("midrst_busy", busy, 64'h0);
    chk("midrst_full", 64'(full), 64'h0);
    chk("midrst_tag", 64'(alloc_tag), 64'h0);
    tick(); rst = 1'b0;
    rsp_valid = 1'b1; rsp_is_rd = 1'b0; rsp_tag = 6'd3; tick();
`ifdef CM_ERR_CNT_EN
    rsp_tag = 6'd4; tick();
    rsp_tag = 6'd5; tick();
    rsp_valid = 1'b0;
    chk("unexp_cnt", 64'(unexp_cnt), 64'd3);
    chk("dup_cnt", 64'(dup_cnt), 64'd0);
`endif
    rsp_valid = 1'b0;
    chk("post_rst_unexp", 64'(err_unexp), 64'h1);
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
